// File: rtl/soc_pkg.sv
// Shared SoC definitions for the DMA engine: FSM state encoding and register word offsets.
package soc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_ADDR,
        ST_RD_DATA,
        ST_WR,
        ST_WR_RESP,
        ST_DONE
    } dma_state_e;

    // Register offsets as word index (byte address bits [4:2])
    localparam logic [2:0] DMA_REG_SRC    = 3'd0;
    localparam logic [2:0] DMA_REG_DST    = 3'd1;
    localparam logic [2:0] DMA_REG_LEN    = 3'd2;
    localparam logic [2:0] DMA_REG_CTRL   = 3'd3;
    localparam logic [2:0] DMA_REG_STATUS = 3'd4;

endpackage

// File: rtl/axi_lite_dma_regs.sv
// AXI-lite slave handshake and configuration register file for the DMA engine.
// Exports a raw start pulse and a done-clear pulse; the engine decides whether to honour start.
module axi_lite_dma_regs
    import soc_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] s_awaddr,
    input  logic              s_awvalid,
    output logic              s_awready,
    input  logic [31:0]       s_wdata,
    input  logic [3:0]        s_wstrb,
    input  logic              s_wvalid,
    output logic              s_wready,
    output logic              s_bvalid,
    input  logic              s_bready,
    input  logic [ADDR_W-1:0] s_araddr,
    input  logic              s_arvalid,
    output logic              s_arready,
    output logic [31:0]       s_rdata,
    output logic              s_rvalid,
    input  logic              s_rready,
    input  logic              busy,
    input  logic              done,
    output logic              start,
    output logic              done_clr,
    output logic [ADDR_W-1:0] cfg_src,
    output logic [ADDR_W-1:0] cfg_dst,
    output logic [LEN_W-1:0]  cfg_len
);

    logic              bvalid_q, bvalid_d;
    logic              rvalid_q, rvalid_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [2:0]        woff, roff;
    logic              wr_fire, rd_fire;
    logic [31:0]       rmux;
    logic              unused;

    assign woff      = s_awaddr[4:2];
    assign roff      = s_araddr[4:2];
    assign wr_fire   = s_awvalid && s_wvalid && !bvalid_q && !rvalid_q;
    assign s_awready = wr_fire;
    assign s_wready  = wr_fire;
    // A write that is ready to go takes priority over a read arriving the same cycle
    assign s_arready = !rvalid_q && !bvalid_q && !(s_awvalid && s_wvalid);
    assign rd_fire   = s_arvalid && s_arready;

    assign start    = wr_fire && (woff == DMA_REG_CTRL) && s_wdata[0];
    assign done_clr = wr_fire && (woff == DMA_REG_STATUS) && s_wdata[1];

    assign s_bvalid = bvalid_q;
    assign s_rvalid = rvalid_q;
    assign s_rdata  = rdata_q;
    assign cfg_src  = src_q;
    assign cfg_dst  = dst_q;
    assign cfg_len  = len_q;
    assign unused   = ^{s_awaddr[ADDR_W-1:5], s_awaddr[1:0], s_araddr[ADDR_W-1:5], s_araddr[1:0], s_wstrb};

    always_comb begin
        rmux = 32'd0;
        case (roff)
            DMA_REG_SRC:    rmux = 32'(src_q);
            DMA_REG_DST:    rmux = 32'(dst_q);
            DMA_REG_LEN:    rmux = 32'(len_q);
            DMA_REG_STATUS: rmux = {30'd0, done, busy};
            default:        rmux = 32'd0;
        endcase
    end

    always_comb begin
        bvalid_d = bvalid_q;
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        src_d    = src_q;
        dst_d    = dst_q;
        len_d    = len_q;
        if (wr_fire)       bvalid_d = 1'b1;
        else if (s_bready) bvalid_d = 1'b0;
        if (rd_fire) begin
            rvalid_d = 1'b1;
            rdata_d  = rmux;
        end else if (s_rready) begin
            rvalid_d = 1'b0;
        end
        if (wr_fire && !busy) begin
            case (woff)
                DMA_REG_SRC: src_d = ADDR_W'(s_wdata);
                DMA_REG_DST: dst_d = ADDR_W'(s_wdata) & ~ADDR_W'(3);
                DMA_REG_LEN: len_d = LEN_W'(s_wdata);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bvalid_q <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= 32'd0;
            src_q    <= '0;
            dst_q    <= '0;
            len_q    <= '0;
        end else begin
            bvalid_q <= bvalid_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            src_q    <= src_d;
            dst_q    <= dst_d;
            len_q    <= len_d;
        end
    end

endmodule

// File: rtl/axi_lite_dma.sv
// Word-copy DMA engine: AXI-lite config slave plus a single-outstanding AXI-lite master
// that reads one word from SRC and writes it to DST, LEN times, then pulses irq_done.
module axi_lite_dma
    import soc_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] s_awaddr,
    input  logic              s_awvalid,
    output logic              s_awready,
    input  logic [31:0]       s_wdata,
    input  logic [3:0]        s_wstrb,
    input  logic              s_wvalid,
    output logic              s_wready,
    output logic              s_bvalid,
    input  logic              s_bready,
    input  logic [ADDR_W-1:0] s_araddr,
    input  logic              s_arvalid,
    output logic              s_arready,
    output logic [31:0]       s_rdata,
    output logic              s_rvalid,
    input  logic              s_rready,
    output logic [ADDR_W-1:0] m_awaddr,
    output logic              m_awvalid,
    input  logic              m_awready,
    output logic [DATA_W-1:0] m_wdata,
    output logic [3:0]        m_wstrb,
    output logic              m_wvalid,
    input  logic              m_wready,
    input  logic              m_bvalid,
    output logic              m_bready,
    output logic [ADDR_W-1:0] m_araddr,
    output logic              m_arvalid,
    input  logic              m_arready,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_rvalid,
    output logic              m_rready,
    output logic              irq_done
);

    dma_state_e        state_q, state_d;
    logic [ADDR_W-1:0] cur_src_q, cur_src_d, cur_dst_q, cur_dst_d;
    logic [LEN_W-1:0]  remain_q, remain_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              aw_ok_q, aw_ok_d, w_ok_q, w_ok_d;
    logic              done_q, done_d;
    logic              busy, start, done_clr;
    logic [ADDR_W-1:0] cfg_src, cfg_dst;
    logic [LEN_W-1:0]  cfg_len;

    assign busy     = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign m_araddr = cur_src_q;
    assign m_awaddr = cur_dst_q;
    assign m_wdata  = data_q;
    assign m_wstrb  = 4'hF;

    axi_lite_dma_regs #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_regs (
        .clk(clk), .rst(rst),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .busy(busy), .done(done_q), .start(start), .done_clr(done_clr),
        .cfg_src(cfg_src), .cfg_dst(cfg_dst), .cfg_len(cfg_len)
    );

    always_comb begin
        state_d   = state_q;
        cur_src_d = cur_src_q;
        cur_dst_d = cur_dst_q;
        remain_d  = remain_q;
        data_d    = data_q;
        aw_ok_d   = aw_ok_q;
        w_ok_d    = w_ok_q;
        m_arvalid = 1'b0;
        m_rready  = 1'b0;
        m_awvalid = 1'b0;
        m_wvalid  = 1'b0;
        m_bready  = 1'b0;
        irq_done  = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                irq_done = (state_q == ST_DONE);
                state_d  = ST_IDLE;
                if (start) begin
                    if (cfg_len == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        cur_src_d = cfg_src;
                        cur_dst_d = cfg_dst;
                        remain_d  = cfg_len;
                        state_d   = ST_RD_ADDR;
                    end
                end
            end
            ST_RD_ADDR: begin
                m_arvalid = 1'b1;
                if (m_arready) state_d = ST_RD_DATA;
            end
            ST_RD_DATA: begin
                m_rready = 1'b1;
                if (m_rvalid) begin
                    data_d  = m_rdata;
                    state_d = ST_WR;
                end
            end
            ST_WR: begin
                // AW and W complete independently; each valid drops once its own handshake is seen
                m_awvalid = !aw_ok_q;
                m_wvalid  = !w_ok_q;
                aw_ok_d   = aw_ok_q || m_awready;
                w_ok_d    = w_ok_q || m_wready;
                if (aw_ok_d && w_ok_d) begin
                    aw_ok_d = 1'b0;
                    w_ok_d  = 1'b0;
                    state_d = ST_WR_RESP;
                end
            end
            ST_WR_RESP: begin
                m_bready = 1'b1;
                if (m_bvalid) begin
                    cur_src_d = cur_src_q + ADDR_W'(4);
                    cur_dst_d = cur_dst_q + ADDR_W'(4);
                    remain_d  = remain_q - LEN_W'(1);
                    state_d   = (remain_q == LEN_W'(1)) ? ST_DONE : ST_RD_ADDR;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Entering DONE overrides a simultaneous firmware clear
        done_d = done_q;
        if (done_clr)             done_d = 1'b0;
        if (state_d == ST_DONE)   done_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cur_src_q <= '0;
            cur_dst_q <= '0;
            remain_q  <= '0;
            data_q    <= '0;
            aw_ok_q   <= 1'b0;
            w_ok_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_src_q <= cur_src_d;
            cur_dst_q <= cur_dst_d;
            remain_q  <= remain_d;
            data_q    <= data_d;
            aw_ok_q   <= aw_ok_d;
            w_ok_q    <= w_ok_d;
            done_q    <= done_d;
        end
    end

endmodule

// File: tb/tb_axi_lite_dma.sv
// Directed bench for axi_lite_dma: register table, copies against a memory-model slave with
// programmable stalls, LEN=0, busy-time writes and mid-transfer reset.
module tb_axi_lite_dma;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata;
    logic [3:0]  s_wstrb;
    logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
    logic        s_arvalid, s_arready, s_rvalid, s_rready;
    logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
    logic [3:0]  m_wstrb;
    logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic        m_arvalid, m_arready, m_rvalid, m_rready, irq_done;

    always #5 clk = ~clk;

    axi_lite_dma #(.ADDR_W(32), .DATA_W(32), .LEN_W(16)) dut (
        .clk(clk), .rst(rst),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .irq_done(irq_done)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        checks++;
        failures++;
        $display("FAIL %s: got no handshake expected one within bound", nm);
    endtask

    // ---------------- memory-model slave on the master port ----------------
    logic [31:0] mem [logic [31:0]];
    int ar_stall = 0, r_stall = 0, aw_stall = 0, w_stall = 0, b_stall = 0;
    int ar_age, r_age, aw_age, w_age, b_age;
    logic rd_pend, aw_got, w_got, b_pend;
    logic [31:0] rd_data, wa, wd;
    int ar_cnt, aw_cnt, irq_cnt, arv_seen, awv_seen, stab_err;
    logic p_ar, p_aw, p_w;
    logic [31:0] p_araddr, p_awaddr, p_wdata;

    initial begin
        m_arready = 0; m_rvalid = 0; m_rdata = 0; m_awready = 0; m_wready = 0; m_bvalid = 0;
        rd_pend = 0; aw_got = 0; w_got = 0; b_pend = 0; rd_data = 0; wa = 0; wd = 0;
        ar_age = 0; r_age = 0; aw_age = 0; w_age = 0; b_age = 0;
        ar_cnt = 0; aw_cnt = 0; irq_cnt = 0; arv_seen = 0; awv_seen = 0; stab_err = 0;
        p_ar = 0; p_aw = 0; p_w = 0; p_araddr = 0; p_awaddr = 0; p_wdata = 0;
        forever begin
            @(negedge clk);
            m_arready = m_arvalid && (ar_age >= ar_stall);
            m_rvalid  = rd_pend && (r_age >= r_stall);
            m_rdata   = rd_data;
            m_awready = m_awvalid && (aw_age >= aw_stall);
            m_wready  = m_wvalid && (w_age >= w_stall);
            m_bvalid  = b_pend && (b_age >= b_stall);
            #4;
            if (rst) begin
                rd_pend = 0; aw_got = 0; w_got = 0; b_pend = 0;
                ar_age = 0; r_age = 0; aw_age = 0; w_age = 0; b_age = 0;
                p_ar = 0; p_aw = 0; p_w = 0;
            end else begin
                if (p_ar && (!m_arvalid || m_araddr !== p_araddr)) stab_err++;
                if (p_aw && (!m_awvalid || m_awaddr !== p_awaddr)) stab_err++;
                if (p_w && (!m_wvalid || m_wdata !== p_wdata)) stab_err++;
                p_ar = m_arvalid && !m_arready; p_araddr = m_araddr;
                p_aw = m_awvalid && !m_awready; p_awaddr = m_awaddr;
                p_w  = m_wvalid && !m_wready;   p_wdata  = m_wdata;
                if (m_arvalid) arv_seen++;
                if (m_awvalid) awv_seen++;
                if (irq_done) irq_cnt++;
                if (m_rvalid && m_rready) rd_pend = 0;
                else if (rd_pend) r_age++;
                if (m_arvalid && m_arready) begin
                    ar_cnt++; ar_age = 0; rd_pend = 1; r_age = 0;
                    rd_data = mem.exists(m_araddr) ? mem[m_araddr] : 32'hBAD0_BAD0;
                end else if (m_arvalid) ar_age++;
                if (m_bvalid && m_bready) b_pend = 0;
                else if (b_pend) b_age++;
                if (m_awvalid && m_awready) begin
                    aw_cnt++; aw_age = 0; aw_got = 1; wa = m_awaddr;
                end else if (m_awvalid) aw_age++;
                if (m_wvalid && m_wready) begin
                    w_age = 0; w_got = 1; wd = m_wdata;
                end else if (m_wvalid) w_age++;
                if (aw_got && w_got) begin
                    mem[wa] = wd; aw_got = 0; w_got = 0; b_pend = 1; b_age = 0;
                end
            end
        end
    end

    // ---------------- config-port tasks ----------------
    task automatic cfg_wr(input logic [31:0] a, input logic [31:0] d);
        int n;
        n = 0;
        @(negedge clk);
        s_awaddr = a; s_wdata = d; s_awvalid = 1; s_wvalid = 1;
        #4;
        while (!s_awready && n < 50) begin @(negedge clk); #4; n++; end
        if (!s_awready) timeout("cfg_wr");
        @(negedge clk);
        s_awvalid = 0; s_wvalid = 0;
    endtask

    task automatic cfg_rd(input logic [31:0] a, output logic [31:0] d);
        int n;
        n = 0;
        d = 32'hFFFF_FFFF;
        @(negedge clk);
        s_araddr = a; s_arvalid = 1;
        #4;
        while (!s_arready && n < 50) begin @(negedge clk); #4; n++; end
        if (!s_arready) timeout("cfg_rd_ar");
        @(negedge clk);
        s_arvalid = 0;
        #4;
        n = 0;
        while (!s_rvalid && n < 50) begin @(negedge clk); #4; n++; end
        if (!s_rvalid) timeout("cfg_rd_r");
        else d = s_rdata;
    endtask

    task automatic rd_chk(input string nm, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        cfg_rd(a, d);
        chk(nm, d, exp);
    endtask

    task automatic clr_cnt();
        ar_cnt = 0; aw_cnt = 0; irq_cnt = 0; arv_seen = 0; awv_seen = 0; stab_err = 0;
    endtask

    task automatic wait_irq(input string nm);
        int n;
        n = 0;
        while (irq_cnt == 0 && n < 2000) begin @(negedge clk); n++; end
        if (irq_cnt == 0) timeout(nm);
        repeat (4) @(negedge clk);
    endtask

    task automatic set_stall(input int ar, input int r, input int aw, input int w, input int b);
        ar_stall = ar; r_stall = r; aw_stall = aw; w_stall = w; b_stall = b;
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic [31:0] raddr;
        logic [31:0] exp;
        string       nm;
    } reg_vec_t;

    reg_vec_t tv[10];

    initial begin
        tv[0] = '{1'b0, 32'h00, 32'h0,         32'h00, 32'h0,         "rst_src"};
        tv[1] = '{1'b0, 32'h00, 32'h0,         32'h10, 32'h0,         "rst_status"};
        tv[2] = '{1'b1, 32'h00, 32'h1000_0004, 32'h00, 32'h1000_0004, "src_rw"};
        tv[3] = '{1'b1, 32'h04, 32'h2000_0003, 32'h04, 32'h2000_0000, "dst_align"};
        tv[4] = '{1'b1, 32'h08, 32'hABCD_0003, 32'h08, 32'h0000_0003, "len_trunc"};
        tv[5] = '{1'b1, 32'h0C, 32'h0,         32'h0C, 32'h0,         "ctrl_reads0"};
        tv[6] = '{1'b1, 32'h14, 32'hFFFF_FFFF, 32'h14, 32'h0,         "unmapped_14"};
        tv[7] = '{1'b1, 32'h1C, 32'h1234_5678, 32'h00, 32'h1000_0004, "unmapped_wr_drop"};
        tv[8] = '{1'b0, 32'h00, 32'h0,         32'h20, 32'h1000_0004, "addr_alias"};
        tv[9] = '{1'b0, 32'h00, 32'h0,         32'h08, 32'h0000_0003, "len_keep"};

        s_awaddr = 0; s_wdata = 0; s_wstrb = 4'hF; s_awvalid = 0; s_wvalid = 0;
        s_araddr = 0; s_arvalid = 0; s_bready = 1; s_rready = 1;
        for (int i = 0; i < 4; i++) mem[32'h1000_0000 + 32'(i * 4)] = 32'hA0A0_0000 + 32'(i);
        repeat (2) @(negedge clk);
        rst = 0;
        chk("rst_valids", {31'd0, m_arvalid | m_awvalid | m_wvalid | m_rready | m_bready | irq_done}, 32'd0);

        // 1: register table
        for (int i = 0; i < 10; i++) begin
            if (tv[i].wr) cfg_wr(tv[i].waddr, tv[i].wdata);
            rd_chk(tv[i].nm, tv[i].raddr, tv[i].exp);
        end

        // 2: zero-wait copy of 4 words
        set_stall(0, 0, 0, 0, 0);
        cfg_wr(32'h00, 32'h1000_0000);
        cfg_wr(32'h04, 32'h1000_0100);
        cfg_wr(32'h08, 32'd4);
        clr_cnt();
        cfg_wr(32'h0C, 32'd1);
        wait_irq("t2_irq_wait");
        for (int i = 0; i < 4; i++)
            chk("t2_dst_word", mem[32'h1000_0100 + 32'(i * 4)], 32'hA0A0_0000 + 32'(i));
        chk("t2_ar_count", 32'(ar_cnt), 32'd4);
        chk("t2_aw_count", 32'(aw_cnt), 32'd4);
        chk("t2_irq_once", 32'(irq_cnt), 32'd1);
        rd_chk("t2_status", 32'h10, 32'h2);

        // 3: LEN=0
        cfg_wr(32'h10, 32'h2);
        rd_chk("t3_done_clr", 32'h10, 32'h0);
        cfg_wr(32'h08, 32'd0);
        clr_cnt();
        cfg_wr(32'h0C, 32'd1);
        chk("t3_irq_next", {31'd0, irq_done}, 32'd1);
        repeat (10) @(negedge clk);
        chk("t3_no_ar", 32'(arv_seen), 32'd0);
        chk("t3_no_aw", 32'(awv_seen), 32'd0);
        chk("t3_irq_once", 32'(irq_cnt), 32'd1);
        rd_chk("t3_status", 32'h10, 32'h2);

        // 4: back-pressure, AW before W then W before AW
        for (int k = 0; k < 2; k++) begin
            if (k == 0) set_stall(5, 0, 0, 5, 5);
            else        set_stall(5, 0, 5, 0, 5);
            cfg_wr(32'h00, 32'h1000_0004);
            cfg_wr(32'h04, 32'h1000_0180 + 32'(k * 16));
            cfg_wr(32'h08, 32'd2);
            clr_cnt();
            cfg_wr(32'h0C, 32'd1);
            wait_irq("t4_irq_wait");
            chk("t4_word0", mem[32'h1000_0180 + 32'(k * 16)], 32'hA0A0_0001);
            chk("t4_word1", mem[32'h1000_0184 + 32'(k * 16)], 32'hA0A0_0002);
            chk("t4_stable", 32'(stab_err), 32'd0);
            chk("t4_aw_count", 32'(aw_cnt), 32'd2);
        end

        // 5: config writes while busy are ignored
        set_stall(5, 0, 5, 5, 5);
        cfg_wr(32'h10, 32'h2);
        cfg_wr(32'h00, 32'h1000_0000);
        cfg_wr(32'h04, 32'h1000_0200);
        cfg_wr(32'h08, 32'd3);
        clr_cnt();
        cfg_wr(32'h0C, 32'd1);
        rd_chk("t5_busy", 32'h10, 32'h1);
        cfg_wr(32'h04, 32'hDEAD_0000);
        cfg_wr(32'h0C, 32'd1);
        wait_irq("t5_irq_wait");
        for (int i = 0; i < 3; i++)
            chk("t5_dst_word", mem[32'h1000_0200 + 32'(i * 4)], 32'hA0A0_0000 + 32'(i));
        chk("t5_no_dead", {31'd0, mem.exists(32'hDEAD_0000)}, 32'd0);
        chk("t5_ar_count", 32'(ar_cnt), 32'd3);
        chk("t5_irq_once", 32'(irq_cnt), 32'd1);
        rd_chk("t5_dst_kept", 32'h04, 32'h1000_0200);
        cfg_wr(32'h10, 32'h2);
        rd_chk("t5_done_clr", 32'h10, 32'h0);

        // 6: reset while word 2 sits in RD_DATA
        set_stall(0, 20, 0, 0, 0);
        cfg_wr(32'h00, 32'h1000_0000);
        cfg_wr(32'h04, 32'h1000_0400);
        cfg_wr(32'h08, 32'd3);
        clr_cnt();
        cfg_wr(32'h0C, 32'd1);
        begin
            int n;
            n = 0;
            while (ar_cnt < 2 && n < 300) begin @(negedge clk); n++; end
            if (ar_cnt < 2) timeout("t6_second_ar");
        end
        chk("t6_in_rd_data", {31'd0, m_rready}, 32'd1);
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("t6_valids_low", {26'd0, m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready, irq_done}, 32'd0);
        rd_chk("t6_status", 32'h10, 32'h0);
        rd_chk("t6_src", 32'h00, 32'h0);
        rd_chk("t6_len", 32'h08, 32'h0);
        set_stall(0, 0, 0, 0, 0);
        cfg_wr(32'h00, 32'h1000_000C);
        cfg_wr(32'h04, 32'h1000_0300);
        cfg_wr(32'h08, 32'd1);
        clr_cnt();
        cfg_wr(32'h0C, 32'd1);
        wait_irq("t6_irq_wait");
        chk("t6_copy", mem[32'h1000_0300], 32'hA0A0_0003);
        chk("t6_ar_count", 32'(ar_cnt), 32'd1);
        rd_chk("t6_status_done", 32'h10, 32'h2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no end expected finish");
        $fatal(1, "timeout");
    end

endmodule
